// File: rtl/acq_sequencer.sv
// Frame-acquisition sequencer: one AD9826 config pass, then N G11620 frames with ping-pong banking.
// Optional watchdog on every wait state when ACQ_SEQ_TIMEOUT_EN is defined; otherwise waits are unbounded.
module acq_sequencer #(
    parameter int                FRAME_W    = 16,
    parameter int                TMO_W      = 24,
    parameter logic [TMO_W-1:0]  TMO_CYCLES = 24'd5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic               cfg_skip_in,
    input  logic [FRAME_W-1:0] frame_num_in,
    output logic               adc_cfg_start_o,
    input  logic               adc_cfg_done_in,
    output logic               g11620_start_o,
    input  logic               ad_sp_in,
    output logic               adc_start_o,
    input  logic               adc_done_in,
    output logic               bank_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic               busy_o,
    output logic               frame_intr_o,
    output logic               run_done_o,
    output logic               err_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_CFG_WAIT,
        S_INTEG,
        S_WAIT_SP_HI,
        S_WAIT_SP_LO,
        S_CAPTURE,
        S_FRAME_END,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               start_r;
    logic               start_edge;
    logic [FRAME_W-1:0] frame_tgt;
    logic [FRAME_W-1:0] frame_cnt_inc;
    logic               frame_last;
    logic               force_done;
    logic               tmo_hit;
    logic               run_start;
    logic               cfg_pulse;
    logic               integ_pulse;
    logic               cap_go;
    logic               frame_end;
    logic               done_pulse;
    logic               adc_start_q;

    assign start_edge    = start_in & ~start_r;
    assign frame_cnt_inc = frame_cnt_o + 1'b1;
    // A zero target means continuous acquisition: the count simply wraps.
    assign frame_last    = (frame_tgt != '0) && (frame_cnt_inc == frame_tgt);
    assign force_done    = (state != S_IDLE) && (state != S_DONE) && (abort_in || tmo_hit);

`ifdef ACQ_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_wait;

    assign tmo_wait = (state == S_CFG_WAIT) || (state == S_WAIT_SP_HI) ||
                      (state == S_WAIT_SP_LO) || (state == S_CAPTURE);
    assign tmo_hit  = tmo_wait && (tmo_cnt == TMO_CYCLES - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (next_state != state) begin
            tmo_cnt <= '0;
        end else if (tmo_wait) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic [TMO_W-1:0] unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = TMO_CYCLES;
`endif

    always_comb begin
        next_state  = state;
        run_start   = 1'b0;
        cfg_pulse   = 1'b0;
        integ_pulse = 1'b0;
        cap_go      = 1'b0;
        frame_end   = 1'b0;
        done_pulse  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge && !abort_in) begin
                    run_start  = 1'b1;
                    next_state = cfg_skip_in ? S_INTEG : S_CFG;
                end
            end
            S_CFG: begin
                cfg_pulse  = 1'b1;
                next_state = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                if (adc_cfg_done_in) begin
                    next_state = S_INTEG;
                end
            end
            S_INTEG: begin
                integ_pulse = 1'b1;
                next_state  = S_WAIT_SP_HI;
            end
            S_WAIT_SP_HI: begin
                if (ad_sp_in) begin
                    next_state = S_WAIT_SP_LO;
                end
            end
            S_WAIT_SP_LO: begin
                if (!ad_sp_in) begin
                    cap_go     = 1'b1;
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (adc_done_in) begin
                    next_state = S_FRAME_END;
                end
            end
            S_FRAME_END: begin
                frame_end  = 1'b1;
                next_state = frame_last ? S_DONE : S_INTEG;
            end
            S_DONE: begin
                done_pulse = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        // Abort/timeout outranks every other transition and suppresses that cycle's pulses.
        if (force_done) begin
            next_state  = S_DONE;
            cfg_pulse   = 1'b0;
            integ_pulse = 1'b0;
            cap_go      = 1'b0;
            frame_end   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start_r     <= 1'b0;
            frame_tgt   <= '0;
            frame_cnt_o <= '0;
            bank_o      <= 1'b0;
            err_o       <= 1'b0;
            adc_start_q <= 1'b0;
        end else begin
            state       <= next_state;
            start_r     <= start_in;
            adc_start_q <= cap_go;
            if (run_start) begin
                frame_tgt   <= frame_num_in;
                frame_cnt_o <= '0;
                bank_o      <= 1'b0;
                err_o       <= 1'b0;
            end else if (frame_end) begin
                frame_cnt_o <= frame_cnt_inc;
                bank_o      <= ~bank_o;
            end
            if (force_done) begin
                err_o <= 1'b1;
            end
        end
    end

    // Capture start is registered so it lands the cycle after AD_SP is seen low.
    assign adc_start_o     = adc_start_q;
    assign adc_cfg_start_o = cfg_pulse;
    assign g11620_start_o  = integ_pulse;
    assign frame_intr_o    = frame_end;
    assign run_done_o      = done_pulse;
    assign busy_o          = (state != S_IDLE);

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: directed runs push expected frame/run-end records, a monitor pops them.
module tb_acq_sequencer;

    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n, start_in, abort_in, cfg_skip_in;
    logic [FW-1:0] frame_num_in;
    logic          adc_cfg_start_o, adc_cfg_done_in, g11620_start_o, ad_sp_in;
    logic          adc_start_o, adc_done_in, bank_o, busy_o, frame_intr_o, run_done_o, err_o;
    logic [FW-1:0] frame_cnt_o;

    typedef struct {
        int cnt;
        int bank;
        int err;
    } exp_t;

    exp_t exp_frame[$];
    exp_t exp_done[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_cfg = 0, n_g = 0, n_as = 0, n_fi = 0;
    int s_cfg, s_g, s_as, s_fi;

    acq_sequencer #(.FRAME_W(FW), .TMO_W(24), .TMO_CYCLES(24'd100)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
        .cfg_skip_in(cfg_skip_in), .frame_num_in(frame_num_in),
        .adc_cfg_start_o(adc_cfg_start_o), .adc_cfg_done_in(adc_cfg_done_in),
        .g11620_start_o(g11620_start_o), .ad_sp_in(ad_sp_in),
        .adc_start_o(adc_start_o), .adc_done_in(adc_done_in),
        .bank_o(bank_o), .frame_cnt_o(frame_cnt_o), .busy_o(busy_o),
        .frame_intr_o(frame_intr_o), .run_done_o(run_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return adc_cfg_start_o;
            1:       return g11620_start_o;
            2:       return adc_start_o;
            3:       return run_done_o;
            default: return frame_intr_o;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string name);
        int k = 0;
        while (!sig(which) && k < limit) begin
            tick();
            k++;
        end
        if (!sig(which)) fail_now(name);
    endtask

    task automatic snap();
        s_cfg = n_cfg; s_g = n_g; s_as = n_as; s_fi = n_fi;
    endtask

    // mode 0: normal frame, 1: abort together with adc_done, 2: stop inside CAPTURE
    task automatic do_frame(input int cnt, input int bank, input int mode);
        exp_t e;
        wait_for(1, 10, "integ_wait");
        tick();
        repeat (3) tick();
        ad_sp_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) start_in = 1'b1;
            if (i == 5) start_in = 1'b0;
            tick();
        end
        ad_sp_in = 1'b0;
        chk("adc_start_early", adc_start_o, 0);
        tick();
        chk("adc_start_latency", adc_start_o, 1);
        tick();
        chk("adc_start_width", adc_start_o, 0);
        if (mode == 2) return;
        repeat (47) tick();
        e.cnt = cnt; e.bank = bank;
        if (mode == 1) begin
            e.err = 1;
            exp_done.push_back(e);
            abort_in = 1'b1;
        end else begin
            e.err = 0;
            exp_frame.push_back(e);
        end
        adc_done_in = 1'b1;
        tick();
        adc_done_in = 1'b0;
        abort_in    = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (adc_cfg_start_o) n_cfg++;
        if (g11620_start_o)  n_g++;
        if (adc_start_o)     n_as++;
        if (frame_intr_o) begin
            n_fi++;
            if (exp_frame.size() == 0) begin
                fail_now("frame_intr_unexpected");
            end else begin
                e = exp_frame.pop_front();
                chk("intr_frame_cnt", int'(frame_cnt_o), e.cnt);
                chk("intr_bank", int'(bank_o), e.bank);
            end
        end
        if (run_done_o) begin
            if (exp_done.size() == 0) begin
                fail_now("run_done_unexpected");
            end else begin
                e = exp_done.pop_front();
                chk("done_frame_cnt", int'(frame_cnt_o), e.cnt);
                chk("done_bank", int'(bank_o), e.bank);
                chk("done_err", int'(err_o), e.err);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   k;
        rst_n = 1'b0; start_in = 1'b0; abort_in = 1'b0; cfg_skip_in = 1'b0;
        frame_num_in = '0; adc_cfg_done_in = 1'b0; ad_sp_in = 1'b0; adc_done_in = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_bank", bank_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_pulses", {adc_cfg_start_o, g11620_start_o, adc_start_o, frame_intr_o, run_done_o}, 0);
        rst_n = 1'b1;
        tick();

        // three-frame run with configuration pass
        snap();
        cfg_skip_in = 1'b0; frame_num_in = 4'd3; start_in = 1'b1;
        wait_for(0, 5, "cfg_start_wait");
        start_in = 1'b0;
        chk("t1_busy", busy_o, 1);
        tick();
        chk("cfg_start_width", adc_cfg_start_o, 0);
        repeat (18) tick();
        adc_cfg_done_in = 1'b1;
        tick();
        adc_cfg_done_in = 1'b0;
        for (int f = 0; f < 3; f++) do_frame(f, f % 2, 0);
        e.cnt = 3; e.bank = 1; e.err = 0;
        exp_done.push_back(e);
        wait_for(3, 5, "t1_run_done");
        tick();
        chk("t1_cfg_pulses", n_cfg - s_cfg, 1);
        chk("t1_integ_pulses", n_g - s_g, 3);
        chk("t1_adc_start_pulses", n_as - s_as, 3);
        chk("t1_frame_intr", n_fi - s_fi, 3);
        chk("t1_busy_end", busy_o, 0);
        chk("t1_err_end", err_o, 0);

        // continuous mode with wrap, then abort
        snap();
        cfg_skip_in = 1'b1; frame_num_in = 4'd0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int f = 0; f < 18; f++) begin
            do_frame(f % 16, f % 2, 0);
            if (f == 15) begin
                tick();
                chk("cnt_wrap", frame_cnt_o, 0);
                chk("bank_after_16", bank_o, 0);
            end
        end
        wait_for(1, 10, "t2_integ_wait");
        tick();
        e.cnt = 2; e.bank = 0; e.err = 1;
        exp_done.push_back(e);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("t2_abort_done", run_done_o, 1);
        chk("t2_abort_err", err_o, 1);
        tick();
        chk("t2_busy_end", busy_o, 0);
        chk("t2_err_sticky", err_o, 1);
        chk("t2_no_cfg", n_cfg - s_cfg, 0);
        chk("t2_frame_intr", n_fi - s_fi, 18);

        // abort coinciding with adc_done in frame 2 of 5
        snap();
        frame_num_in = 4'd5; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("t3_err_cleared", err_o, 0);
        chk("t3_cnt_cleared", frame_cnt_o, 0);
        do_frame(0, 0, 0);
        do_frame(1, 1, 1);
        chk("t3_done_next", run_done_o, 1);
        chk("t3_cnt_hold", frame_cnt_o, 1);
        tick();
        chk("t3_frame_intr", n_fi - s_fi, 1);
        chk("t3_busy_end", busy_o, 0);

        // restart clears err; reset during capture
        frame_num_in = 4'd3; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("t4_err_cleared", err_o, 0);
        do_frame(0, 0, 0);
        do_frame(1, 1, 2);
        chk("t4_pre_busy", busy_o, 1);
        chk("t4_pre_cnt", frame_cnt_o, 1);
        chk("t4_pre_bank", bank_o, 1);
        rst_n = 1'b0;
        tick();
        chk("t4_rst_busy", busy_o, 0);
        chk("t4_rst_cnt", frame_cnt_o, 0);
        chk("t4_rst_bank", bank_o, 0);
        rst_n = 1'b1;
        tick();

        // stuck AD_SP: watchdog or unbounded wait
        frame_num_in = 4'd1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        wait_for(1, 10, "t5_integ_wait");
        tick();
`ifdef ACQ_SEQ_TIMEOUT_EN
        e.cnt = 0; e.bank = 0; e.err = 1;
        exp_done.push_back(e);
        k = 0;
        while (!run_done_o && k < 300) begin
            tick();
            k++;
        end
        chk("t5_timeout_cycles", k, 100);
        chk("t5_timeout_err", err_o, 1);
        tick();
`else
        repeat (10000) tick();
        chk("t5_still_waiting", busy_o, 1);
        chk("t5_no_err", err_o, 0);
        e.cnt = 0; e.bank = 0; e.err = 1;
        exp_done.push_back(e);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("t5_abort_done", run_done_o, 1);
        tick();
`endif
        chk("t5_busy_end", busy_o, 0);
        chk("pending_frames", exp_frame.size(), 0);
        chk("pending_done", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
